// File: rtl/store_buffer.sv
// Store buffer: holds stores from dispatch until ROB commit, then drains them to memory in order.
// Also forwards data from older stores to loads.
module store_buffer #(
  parameter int SB_ENTRY    = 8,
  parameter int WORD_SIZE_P = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        alloc_valid_i,
  output logic                        alloc_ready_o,
  output logic [$clog2(SB_ENTRY)-1:0] alloc_idx_o,
  input  logic                        wr_valid_i,
  input  logic [$clog2(SB_ENTRY)-1:0] wr_idx_i,
  input  logic [WORD_SIZE_P-1:0]      wr_addr_i,
  input  logic [WORD_SIZE_P-1:0]      wr_data_i,
  input  logic                        rob_sb_valid_i,
  input  logic                        rob_mispredict_i,
  output logic                        mem_valid_o,
  input  logic                        mem_ready_i,
  output logic [WORD_SIZE_P-1:0]      mem_addr_o,
  output logic [WORD_SIZE_P-1:0]      mem_data_o,
  input  logic [WORD_SIZE_P-1:0]      ld_addr_i,
  input  logic [$clog2(SB_ENTRY)-1:0] ld_sb_pt_i,
  output logic                        ld_hit_o,
  output logic [WORD_SIZE_P-1:0]      ld_data_o,
  output logic                        ld_stall_o,
  output logic                        sb_empty_o,
  output logic                        sb_err_o,
  output logic [2*SB_ENTRY-1:0]       dbg_state_o
);

  localparam int IW = $clog2(SB_ENTRY);

  // Entry state, also visible on dbg_state_o (2 bits per entry, entry i at [2i+1:2i]).
  typedef enum logic [1:0] {
    E_FREE   = 2'd0,
    E_ALLOC  = 2'd1,
    E_READY  = 2'd2,
    E_COMMIT = 2'd3
  } entry_st_e;

  entry_st_e               st_q [SB_ENTRY];
  entry_st_e               st_n [SB_ENTRY];
  logic [WORD_SIZE_P-1:0]  addr_q [SB_ENTRY];
  logic [WORD_SIZE_P-1:0]  data_q [SB_ENTRY];
  logic [IW-1:0]           drain_pt_q, commit_pt_q, alloc_pt_q;
  logic [IW-1:0]           drain_pt_n, commit_pt_n, alloc_pt_n;
  logic [IW:0]             count_q, count_n, n_comm;
  logic                    err_q;
  logic                    alloc_fire, fill_fire, drain_fire;

  // Handshakes: a transfer happens in a cycle where valid and ready are both high at the
  // rising edge; valid never depends on ready, and payload is stable while valid waits.
  assign alloc_ready_o = count_q < (IW+1)'(SB_ENTRY);
  assign alloc_idx_o   = alloc_pt_q;
  assign mem_valid_o   = (st_q[drain_pt_q] == E_COMMIT);
  assign mem_addr_o    = mem_valid_o ? addr_q[drain_pt_q] : '0;
  assign mem_data_o    = mem_valid_o ? data_q[drain_pt_q] : '0;
  assign sb_empty_o    = (count_q == '0);
  assign sb_err_o      = err_q;

  // A flush discards any alloc or fill presented in the same cycle.
  assign alloc_fire = alloc_valid_i & alloc_ready_o & ~rob_mispredict_i;
  assign fill_fire  = wr_valid_i & (st_q[wr_idx_i] == E_ALLOC) & ~rob_mispredict_i;
  assign drain_fire = mem_valid_o & mem_ready_i;

  always_comb begin
    st_n = st_q;
    if (alloc_fire)     st_n[alloc_pt_q]  = E_ALLOC;
    if (fill_fire)      st_n[wr_idx_i]    = E_READY;
    if (rob_sb_valid_i) st_n[commit_pt_q] = E_COMMIT;
    if (drain_fire)     st_n[drain_pt_q]  = E_FREE;
    n_comm = '0;
    for (int i = 0; i < SB_ENTRY; i++) begin
      if (rob_mispredict_i && (st_n[i] == E_ALLOC || st_n[i] == E_READY)) st_n[i] = E_FREE;
      if (st_n[i] == E_COMMIT) n_comm = n_comm + (IW+1)'(1);
    end
    drain_pt_n  = drain_fire ? drain_pt_q + IW'(1) : drain_pt_q;
    commit_pt_n = rob_sb_valid_i ? commit_pt_q + IW'(1) : commit_pt_q;
    if (rob_mispredict_i) begin
      alloc_pt_n = commit_pt_n;
      count_n    = n_comm;
    end else begin
      alloc_pt_n = alloc_fire ? alloc_pt_q + IW'(1) : alloc_pt_q;
      count_n    = count_q + (IW+1)'(alloc_fire) - (IW+1)'(drain_fire);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < SB_ENTRY; i++) st_q[i] <= E_FREE;
      drain_pt_q  <= '0;
      commit_pt_q <= '0;
      alloc_pt_q  <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < SB_ENTRY; i++) st_q[i] <= st_n[i];
      drain_pt_q  <= drain_pt_n;
      commit_pt_q <= commit_pt_n;
      alloc_pt_q  <= alloc_pt_n;
      count_q     <= count_n;
      if (rob_sb_valid_i && st_q[commit_pt_q] != E_READY) err_q <= 1'b1;
    end
  end

  // Payload is only observed once its entry is READY or COMMITTED, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (fill_fire) begin
      addr_q[wr_idx_i] <= wr_addr_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  logic [IW-1:0] fwd_win, fwd_idx;

  // Walk oldest to youngest so the last matching entry wins.
  always_comb begin
    ld_hit_o   = 1'b0;
    ld_stall_o = 1'b0;
    ld_data_o  = '0;
    fwd_idx    = '0;
    fwd_win    = ld_sb_pt_i - drain_pt_q;
    for (int i = 0; i < SB_ENTRY; i++) begin
      fwd_idx = drain_pt_q + IW'(i);
      if (IW'(i) < fwd_win) begin
        if (st_q[fwd_idx] == E_ALLOC) begin
          ld_stall_o = 1'b1;
        end else if (st_q[fwd_idx] != E_FREE && addr_q[fwd_idx] == ld_addr_i) begin
          ld_hit_o  = 1'b1;
          ld_data_o = data_q[fwd_idx];
        end
      end
    end
    if (ld_stall_o) begin
      ld_hit_o  = 1'b0;
      ld_data_o = '0;
    end
  end

  always_comb begin
    dbg_state_o = '0;
    for (int i = 0; i < SB_ENTRY; i++) dbg_state_o[2*i +: 2] = st_q[i];
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus a randomized run against a queue-based
// model of the in-flight stores in program order.
module tb_store_buffer;

  localparam int N = 8;

  logic        clk_i, reset_i;
  logic        alloc_valid_i, alloc_ready_o;
  logic [2:0]  alloc_idx_o;
  logic        wr_valid_i;
  logic [2:0]  wr_idx_i;
  logic [15:0] wr_addr_i, wr_data_i;
  logic        rob_sb_valid_i, rob_mispredict_i;
  logic        mem_valid_o, mem_ready_i;
  logic [15:0] mem_addr_o, mem_data_o;
  logic [15:0] ld_addr_i;
  logic [2:0]  ld_sb_pt_i;
  logic        ld_hit_o, ld_stall_o;
  logic [15:0] ld_data_o;
  logic        sb_empty_o, sb_err_o;
  logic [15:0] dbg_state_o;

  store_buffer #(.SB_ENTRY(N), .WORD_SIZE_P(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .wr_valid_i(wr_valid_i), .wr_idx_i(wr_idx_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rob_sb_valid_i(rob_sb_valid_i), .rob_mispredict_i(rob_mispredict_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .ld_addr_i(ld_addr_i), .ld_sb_pt_i(ld_sb_pt_i),
    .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o), .ld_stall_o(ld_stall_o),
    .sb_empty_o(sb_empty_o), .sb_err_o(sb_err_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;

  // model: in-flight stores oldest first; committed ones form a prefix
  typedef struct {
    bit          filled;
    bit          committed;
    logic [15:0] addr;
    logic [15:0] data;
    logic [2:0]  idx;
  } ent_t;

  ent_t       mq[$];
  int         m_ncomm;
  logic [2:0] m_head, m_alloc;
  bit         m_err;

  task automatic model_reset();
    mq.delete();
    m_ncomm = 0;
    m_head  = 3'd0;
    m_alloc = 3'd0;
    m_err   = 1'b0;
  endtask

  task automatic model_update();
    bit   do_drain, do_alloc;
    ent_t t;
    do_drain = (m_ncomm > 0) && mem_ready_i;
    do_alloc = alloc_valid_i && (mq.size() < N) && !rob_mispredict_i;
    if (rob_sb_valid_i && (m_ncomm >= mq.size() || !mq[m_ncomm].filled)) m_err = 1'b1;
    if (wr_valid_i && !rob_mispredict_i) begin
      foreach (mq[p]) begin
        if (mq[p].idx == wr_idx_i && !mq[p].filled && !mq[p].committed) begin
          t = mq[p]; t.filled = 1'b1; t.addr = wr_addr_i; t.data = wr_data_i; mq[p] = t;
        end
      end
    end
    if (rob_sb_valid_i && m_ncomm < mq.size()) begin
      t = mq[m_ncomm]; t.committed = 1'b1; mq[m_ncomm] = t;
      m_ncomm++;
    end
    if (do_drain) begin
      void'(mq.pop_front());
      m_ncomm--;
      m_head = m_head + 3'd1;
    end
    if (rob_mispredict_i) begin
      while (mq.size() > m_ncomm) void'(mq.pop_back());
      m_alloc = m_head + 3'(m_ncomm);
    end
    if (do_alloc) begin
      t = '{filled: 1'b0, committed: 1'b0, addr: 16'h0, data: 16'h0, idx: m_alloc};
      mq.push_back(t);
      m_alloc = m_alloc + 3'd1;
    end
  endtask

  // driver tasks
  task automatic idle();
    alloc_valid_i = 0; wr_valid_i = 0; wr_idx_i = 0; wr_addr_i = 0; wr_data_i = 0;
    rob_sb_valid_i = 0; rob_mispredict_i = 0; mem_ready_i = 0; ld_addr_i = 0; ld_sb_pt_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    idle();
    reset_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({alloc_ready_o, alloc_idx_o, mem_valid_o, sb_empty_o, sb_err_o} !== {1'b1, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b idx=%0d mv=%b empty=%b err=%b exp 1 0 0 1 0",
               alloc_ready_o, alloc_idx_o, mem_valid_o, sb_empty_o, sb_err_o);
    end
    checks++;
    if ({mem_addr_o, mem_data_o, ld_hit_o, ld_stall_o, ld_data_o} !== 50'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%h data=%h hit=%b stall=%b ld=%h exp all 0",
               mem_addr_o, mem_data_o, ld_hit_o, ld_stall_o, ld_data_o);
    end
  endtask

  task automatic test_single_store();
    apply_reset();
    alloc_valid_i = 1; #1;
    checks++;
    if (alloc_idx_o !== 3'd0) begin errors++; $display("FAIL single_idx got %0d exp 0", alloc_idx_o); end
    tick();
    idle(); wr_valid_i = 1; wr_idx_i = 0; wr_addr_i = 16'h0040; wr_data_i = 16'hBEEF;
    tick();
    idle(); rob_sb_valid_i = 1; #1;
    checks++;
    if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL single_early got mv=%b exp 0", mem_valid_o); end
    tick();
    idle(); mem_ready_i = 1; #1;
    checks++;
    if ({mem_valid_o, mem_addr_o, mem_data_o} !== {1'b1, 16'h0040, 16'hBEEF}) begin
      errors++;
      $display("FAIL single_write got mv=%b %h/%h exp 1 0040/beef", mem_valid_o, mem_addr_o, mem_data_o);
    end
    tick(); #1;
    checks++;
    if ({mem_valid_o, sb_empty_o} !== 2'b01) begin
      errors++; $display("FAIL single_done got mv=%b empty=%b exp 0 1", mem_valid_o, sb_empty_o);
    end
    idle();
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < N; i++) begin
      alloc_valid_i = 1; #1;
      checks++;
      if ({alloc_ready_o, alloc_idx_o} !== {1'b1, 3'(i)}) begin
        errors++; $display("FAIL full_alloc got rdy=%b idx=%0d exp 1 %0d", alloc_ready_o, alloc_idx_o, i);
      end
      tick();
    end
    #1;
    checks++;
    if (alloc_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", alloc_ready_o); end
    tick();
    idle();
    for (int i = 0; i < N; i++) begin
      wr_valid_i = 1; wr_idx_i = 3'(i); wr_addr_i = 16'h0100 + 16'(i); wr_data_i = 16'hA000 + 16'(i);
      tick();
    end
    idle();
    for (int i = 0; i < N; i++) begin
      rob_sb_valid_i = 1;
      tick();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({alloc_ready_o, mem_valid_o, mem_addr_o} !== {1'b0, 1'b1, 16'h0100}) begin
        errors++; $display("FAIL full_hold got rdy=%b mv=%b addr=%h exp 0 1 0100", alloc_ready_o, mem_valid_o, mem_addr_o);
      end
      tick();
    end
    mem_ready_i = 1;
    for (int i = 0; i < N; i++) begin
      #1;
      checks++;
      if ({mem_valid_o, mem_addr_o, mem_data_o} !== {1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i)}) begin
        errors++; $display("FAIL full_drain%0d got mv=%b %h/%h", i, mem_valid_o, mem_addr_o, mem_data_o);
      end
      if (i == 1) begin
        checks++;
        if (alloc_ready_o !== 1'b1) begin errors++; $display("FAIL full_freed got %b exp 1", alloc_ready_o); end
      end
      tick();
    end
    #1;
    checks++;
    if ({sb_empty_o, mem_valid_o, alloc_idx_o} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL full_wrap got empty=%b mv=%b idx=%0d exp 1 0 0", sb_empty_o, mem_valid_o, alloc_idx_o);
    end
    idle();
  endtask

  task automatic test_flush();
    int writes;
    apply_reset();
    for (int i = 0; i < 4; i++) begin alloc_valid_i = 1; tick(); end
    idle();
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1; wr_idx_i = 3'(i); wr_addr_i = 16'h0200 + 16'(i); wr_data_i = 16'hC000 + 16'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 2; i++) begin rob_sb_valid_i = 1; tick(); end
    idle();
    rob_mispredict_i = 1; alloc_valid_i = 1;
    tick();
    idle(); #1;
    checks++;
    if ({alloc_idx_o, dbg_state_o[7:0]} !== {3'd2, 8'b0000_1111}) begin
      errors++; $display("FAIL flush_state got idx=%0d st=%b exp 2 00001111", alloc_idx_o, dbg_state_o[7:0]);
    end
    wr_valid_i = 1; wr_idx_i = 3; wr_addr_i = 16'h0300; wr_data_i = 16'hDEAD;
    tick();
    idle(); #1;
    checks++;
    if (dbg_state_o[7:6] !== 2'b00) begin errors++; $display("FAIL flush_late got %b exp 00", dbg_state_o[7:6]); end
    mem_ready_i = 1;
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mem_valid_o) begin
        checks++;
        if ({mem_addr_o, mem_data_o} !== {16'h0200 + 16'(writes), 16'hC000 + 16'(writes)}) begin
          errors++; $display("FAIL flush_data got %h/%h exp write %0d", mem_addr_o, mem_data_o, writes);
        end
        writes++;
      end
      tick();
    end
    checks++;
    if (writes !== 2) begin errors++; $display("FAIL flush_writes got %0d exp 2", writes); end
    checks++;
    if (sb_empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", sb_empty_o); end
    idle();
  endtask

  task automatic test_forward();
    apply_reset();
    for (int i = 0; i < 2; i++) begin alloc_valid_i = 1; tick(); end
    idle();
    wr_valid_i = 1; wr_idx_i = 0; wr_addr_i = 16'h0010; wr_data_i = 16'h1111;
    tick();
    wr_valid_i = 1; wr_idx_i = 1; wr_addr_i = 16'h0010; wr_data_i = 16'h2222;
    ld_addr_i = 16'h0010; ld_sb_pt_i = 2; #1;
    checks++;
    if ({ld_stall_o, ld_hit_o, ld_data_o} !== {1'b1, 1'b0, 16'h0}) begin
      errors++; $display("FAIL fwd_stall got stall=%b hit=%b d=%h exp 1 0 0000", ld_stall_o, ld_hit_o, ld_data_o);
    end
    tick();
    wr_valid_i = 0; #1;
    checks++;
    if ({ld_stall_o, ld_hit_o, ld_data_o} !== {1'b0, 1'b1, 16'h2222}) begin
      errors++; $display("FAIL fwd_young got stall=%b hit=%b d=%h exp 0 1 2222", ld_stall_o, ld_hit_o, ld_data_o);
    end
    ld_sb_pt_i = 1; #1;
    checks++;
    if ({ld_hit_o, ld_data_o} !== {1'b1, 16'h1111}) begin
      errors++; $display("FAIL fwd_old got hit=%b d=%h exp 1 1111", ld_hit_o, ld_data_o);
    end
    ld_sb_pt_i = 0; #1;
    checks++;
    if ({ld_stall_o, ld_hit_o} !== 2'b00) begin
      errors++; $display("FAIL fwd_empty got stall=%b hit=%b exp 0 0", ld_stall_o, ld_hit_o);
    end
    ld_sb_pt_i = 2; ld_addr_i = 16'h0020; #1;
    checks++;
    if ({ld_stall_o, ld_hit_o, ld_data_o} !== 18'd0) begin
      errors++; $display("FAIL fwd_miss got stall=%b hit=%b d=%h exp 0 0 0000", ld_stall_o, ld_hit_o, ld_data_o);
    end
    idle();
  endtask

  task automatic test_err();
    apply_reset();
    alloc_valid_i = 1; tick();
    idle(); rob_sb_valid_i = 1; tick();
    idle(); #1;
    checks++;
    if (sb_err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", sb_err_o); end
    mem_ready_i = 1;
    for (int i = 0; i < 3; i++) tick();
    alloc_valid_i = 1; tick();
    #1;
    checks++;
    if (sb_err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", sb_err_o); end
    apply_reset(); #1;
    checks++;
    if (sb_err_o !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", sb_err_o); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    alloc_valid_i = 1; tick();
    idle(); wr_valid_i = 1; wr_idx_i = 0; wr_addr_i = 16'h0555; wr_data_i = 16'h7777; tick();
    idle(); rob_sb_valid_i = 1; tick();
    idle(); #1;
    checks++;
    if (mem_valid_o !== 1'b1) begin errors++; $display("FAIL arst_pre got mv=%b exp 1", mem_valid_o); end
    reset_i = 1'b0; #1;
    checks++;
    if ({mem_valid_o, mem_addr_o, mem_data_o, alloc_ready_o, alloc_idx_o, sb_empty_o} !==
        {1'b0, 16'h0, 16'h0, 1'b1, 3'd0, 1'b1}) begin
      errors++; $display("FAIL arst_now got mv=%b %h/%h rdy=%b idx=%0d empty=%b",
                         mem_valid_o, mem_addr_o, mem_data_o, alloc_ready_o, alloc_idx_o, sb_empty_o);
    end
    apply_reset();
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 3))
      0: return 16'h0010;
      1: return 16'h0020;
      2: return 16'h0030;
      default: return 16'h0040;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  win;
    logic [2:0]  cand[$];
    logic        e_hit, e_stall, e_mv;
    logic [15:0] e_ld, e_ma, e_md;
    logic [41:0] got, exp;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      alloc_valid_i = ($urandom_range(0, 99) < 50);
      cand.delete();
      foreach (mq[p]) if (!mq[p].filled && !mq[p].committed) cand.push_back(mq[p].idx);
      if (cand.size() > 0 && $urandom_range(0, 99) < 60) begin
        wr_valid_i = 1; wr_idx_i = cand[$urandom_range(0, cand.size() - 1)];
      end else if ($urandom_range(0, 99) < 10) begin
        wr_valid_i = 1; wr_idx_i = 3'($urandom_range(0, 7));
      end
      wr_addr_i = pick_addr(); wr_data_i = 16'($urandom);
      if ($urandom_range(0, 99) < 4) rob_mispredict_i = 1;
      else if (m_ncomm < mq.size() && mq[m_ncomm].filled) rob_sb_valid_i = ($urandom_range(0, 99) < 50);
      mem_ready_i = ($urandom_range(0, 99) < 60);
      ld_addr_i = pick_addr(); ld_sb_pt_i = 3'($urandom_range(0, 7));
      #1;
      e_hit = 0; e_stall = 0; e_ld = 0;
      win = ld_sb_pt_i - m_head;
      for (int p = 0; p < mq.size() && p < int'(win); p++) begin
        if (!mq[p].filled && !mq[p].committed) e_stall = 1;
        else if (mq[p].addr == ld_addr_i) begin e_hit = 1; e_ld = mq[p].data; end
      end
      if (e_stall) begin e_hit = 0; e_ld = 0; end
      e_mv = (m_ncomm > 0);
      e_ma = e_mv ? mq[0].addr : 16'h0;
      e_md = e_mv ? mq[0].data : 16'h0;
      exp = {(mq.size() < N), m_alloc, e_mv, e_ma, e_md, e_hit, e_stall, (mq.size() == 0), m_err};
      got = {alloc_ready_o, alloc_idx_o, mem_valid_o, mem_addr_o, mem_data_o, ld_hit_o, ld_stall_o, sb_empty_o, sb_err_o};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rand_ctrl cycle %0d got %h exp %h", c, got, exp);
      end
      checks++;
      if (ld_data_o !== e_ld) begin
        errors++; $display("FAIL rand_ld cycle %0d got %h exp %h", c, ld_data_o, e_ld);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    reset_i = 1'b0;
    model_reset();
    test_reset();
    test_single_store();
    test_full_wrap();
    test_flush();
    test_forward();
    test_err();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Holds speculative stores from allocation through execution until the ROB retires them, then drains committed stores to the data memory write port in program order. Sits between rename/dispatch (allocation), the store execution unit (address/data fill), the ROB commit stage (`sb_valid` pop and mispredict flush), the load unit (store-to-load forwarding) and data memory.

## Interface
- `SB_ENTRY`, 8: entries; power of two, ≥2.
- `WORD_SIZE_P`, 16: address and data width.
- `clk_i` in 1: clock, rising edge.
- `reset_i` in 1: reset, asynchronous, active-low.
- `alloc_valid_i` in 1: dispatch requests a store entry.
- `alloc_ready_o` out 1: entry available; equals registered count < `SB_ENTRY`.
- `alloc_idx_o` out `$clog2(SB_ENTRY)`: index granted (= alloc pointer); travels with the store uop.
- `wr_valid_i` in 1: store execute writes address/data.
- `wr_idx_i` in `$clog2(SB_ENTRY)`: target entry.
- `wr_addr_i`, `wr_data_i` in `WORD_SIZE_P` each: resolved address and store data.
- `rob_sb_valid_i` in 1: ROB commits the oldest uncommitted store (already gated by ~mispredict upstream).
- `rob_mispredict_i` in 1: flush all uncommitted entries.
- `mem_valid_o` out 1: head entry committed, write request.
- `mem_ready_i` in 1: memory accepts write.
- `mem_addr_o`, `mem_data_o` out `WORD_SIZE_P` each: head entry contents.
- `ld_addr_i` in `WORD_SIZE_P`: load address for forwarding lookup.
- `ld_sb_pt_i` in `$clog2(SB_ENTRY)`: `alloc_idx_o` sampled when the load dispatched; entries older than it are searched.
- `ld_hit_o` out 1, `ld_data_o` out `WORD_SIZE_P`, `ld_stall_o` out 1: forwarding result.
- `sb_empty_o` out 1: count == 0.
- `sb_err_o` out 1: sticky; commit popped an entry not in READY.

## Operation
- Per-entry state: FREE → ALLOC (alloc handshake) → READY (`wr_valid_i` to that index while in ALLOC) → COMMITTED (ROB pop) → FREE (memory handshake at head).
- Pointers: `drain_pt` (head), `commit_pt` (next to commit), `alloc_pt` (tail); all wrap modulo `SB_ENTRY`. `count` is `$clog2(SB_ENTRY)+1` bits.
- Alloc: on `alloc_valid_i & alloc_ready_o`: entry ALLOC, `alloc_pt`+1, count+1.
- Fill: write to an entry not in ALLOC is ignored (stale, flushed uop).
- Commit: on `rob_sb_valid_i`, entry at `commit_pt` → COMMITTED, `commit_pt`+1. If that entry was not READY, set `sb_err_o`, still advance.
- Drain: `mem_valid_o` = state[`drain_pt`]==COMMITTED; on `mem_valid_o & mem_ready_i`: entry FREE, `drain_pt`+1, count−1. `mem_addr_o`/`mem_data_o` held stable while valid and not ready.
- Flush: on `rob_mispredict_i`, every ALLOC/READY entry → FREE, `alloc_pt` ← `commit_pt`, count ← committed entries remaining after this cycle's drain. COMMITTED entries keep draining. Alloc and fill in the flush cycle are discarded.
- Simultaneous alloc+drain: count unchanged. Commit+drain same entry in one cycle impossible (drain uses registered state).
- Forwarding (combinational): search entries from `drain_pt` up to, not including, `ld_sb_pt_i`. If any searched entry is ALLOC → `ld_stall_o`=1, `ld_hit_o`=0. Else youngest searched READY/COMMITTED entry with address == `ld_addr_i` → `ld_hit_o`=1, `ld_data_o` its data; otherwise 0/0. `ld_sb_pt_i`==`drain_pt` means empty window.

## Timing
- Reset (`reset_i` low, async): all entries FREE, pointers 0, count 0, `sb_err_o` 0; outputs: `alloc_ready_o`=1, `alloc_idx_o`=0, `mem_valid_o`=0, `mem_addr_o`/`mem_data_o`=0, `ld_hit_o`=0, `ld_stall_o`=0, `ld_data_o`=0, `sb_empty_o`=1. Reset mid-drain drops pending writes.
- All state updates at the rising edge; `alloc_ready_o`, `mem_valid_o` derive from registers only.
- Minimum latency alloc → memory write: alloc cycle N, fill N+1, commit N+2, `mem_valid_o` in N+3.
- Full: `alloc_ready_o`=0 while count==`SB_ENTRY`; freed slot visible the cycle after the drain handshake.
- Forwarding outputs valid same cycle as `ld_addr_i`/`ld_sb_pt_i`, reflecting registered state (a same-cycle fill is not seen).

## Test plan
- Single store: alloc (idx 0), fill addr 0x0040 data 0xBEEF, commit, `mem_ready_i`=1 → `mem_valid_o` one cycle with 0x0040/0xBEEF, then `sb_empty_o`=1.
- Fill to 8 entries, `mem_ready_i`=0 after committing all → `alloc_ready_o`=0; release ready → drains idx 0..7 in order, pointers wrap to 0, next alloc idx 0.
- Alloc 4, commit 2, assert `rob_mispredict_i` → entries 2,3 FREE, `alloc_idx_o`=2 next cycle, only 2 memory writes emitted; late fill to idx 3 ignored.
- Forward: stores to 0x0010 data 0x1111 then 0x2222 both READY, load with `ld_sb_pt_i`=2 at 0x0010 → `ld_hit_o`=1, `ld_data_o`=0x2222; with idx 1 still ALLOC → `ld_stall_o`=1.
- Commit pop on ALLOC entry → `sb_err_o`=1 and stays 1 until reset.
- Assert `reset_i` low while `mem_valid_o`=1 → all outputs take reset values immediately, no clock needed.
